// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one memory_interface port between instruction
// fetch and the load/store unit. One access in flight, with alignment checks and a completion timeout.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  output logic                  if_err,
  input  logic                  ls_load,
  input  logic                  ls_store,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  input  logic [1:0]            ls_word_type,
  input  logic                  ls_signed,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  ls_done,
  output logic                  ls_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_load,
  output logic                  mem_store,
  output logic                  mem_is_signed,
  output logic [1:0]            mem_word_type,
  input  logic                  mem_busy,
  input  logic                  mem_output_valid,
  input  logic                  mem_write_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] WT_HALF      = 2'b01;
  localparam logic [1:0] WT_WORD      = 2'b10;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       owner_ls;
  logic       op_store;
  logic       ptr_ls;
  logic [7:0] wait_cnt;

  logic ls_pend, grant_ls, ls_bad, if_bad, complete, wait_end;

  always_comb begin
    ls_pend  = ls_load | ls_store;
    grant_ls = ls_pend & (~if_req | ptr_ls);
    ls_bad   = (ls_load & ls_store) || (ls_word_type == 2'b11) ||
               (ls_word_type == WT_WORD && ls_addr[1:0] != 2'b00) ||
               (ls_word_type == WT_HALF && ls_addr[0]);
    if_bad   = (if_addr[1:0] != 2'b00);
    complete = op_store ? mem_write_ready : mem_output_valid;
    wait_end = complete || (wait_cnt == TIMEOUT_LAST);
  end

  // Strobes decode straight from ISSUE: they fire in the first not-busy cycle only
  // and disappear together with the asynchronous reset of the state register.
  assign mem_load  = (state == ISSUE) && !mem_busy && !op_store;
  assign mem_store = (state == ISSUE) && !mem_busy &&  op_store;

  // NOTE: every register here uses non-blocking assignments so each one sees the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      owner_ls      <= 1'b0;
      op_store      <= 1'b0;
      ptr_ls        <= 1'b0;
      wait_cnt      <= '0;
      if_rdata      <= '0;
      if_valid      <= 1'b0;
      if_err        <= 1'b0;
      ls_rdata      <= '0;
      ls_done       <= 1'b0;
      ls_err        <= 1'b0;
      mem_address   <= '0;
      mem_data_in   <= '0;
      mem_is_signed <= 1'b0;
      mem_word_type <= '0;
    end else begin
      if_valid <= 1'b0;
      if_err   <= 1'b0;
      ls_done  <= 1'b0;
      ls_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || ls_pend) begin
            owner_ls <= grant_ls;
            ptr_ls   <= ~grant_ls;
            wait_cnt <= '0;
            if (grant_ls) begin
              op_store <= ls_store;
              if (ls_bad) begin
                ls_done  <= 1'b1;
                ls_err   <= 1'b1;
                ls_rdata <= '0;
                state    <= RESP;
              end else begin
                mem_address   <= ls_addr;
                mem_data_in   <= ls_store ? ls_wdata : '0;
                mem_word_type <= ls_word_type;
                mem_is_signed <= ls_signed;
                state         <= ISSUE;
              end
            end else begin
              op_store <= 1'b0;
              if (if_bad) begin
                if_err   <= 1'b1;
                if_rdata <= '0;
                state    <= RESP;
              end else begin
                mem_address   <= if_addr;
                mem_data_in   <= '0;
                mem_word_type <= WT_WORD;
                mem_is_signed <= 1'b0;
                state         <= ISSUE;
              end
            end
          end
        end
        ISSUE: if (!mem_busy) state <= WAIT;
        WAIT: begin
          if (wait_end) begin
            state         <= RESP;
            mem_address   <= '0;
            mem_data_in   <= '0;
            mem_word_type <= '0;
            mem_is_signed <= 1'b0;
            if (owner_ls) begin
              ls_done <= 1'b1;
              ls_err  <= ~complete;
              // A completed store leaves the last load result visible.
              if (!complete)     ls_rdata <= '0;
              else if (!op_store) ls_rdata <= mem_data_out;
            end else begin
              if_valid <= complete;
              if_err   <= ~complete;
              if_rdata <= complete ? mem_data_out : '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected strobes and responses,
// independent monitors pop and compare whenever the DUT presents them.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid, if_err;
  logic          ls_load = 1'b0, ls_store = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic [1:0]    ls_word_type = 2'b10;
  logic          ls_signed = 1'b0;
  logic [DW-1:0] ls_rdata;
  logic          ls_done, ls_err;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out = '0;
  logic          mem_load, mem_store, mem_is_signed;
  logic [1:0]    mem_word_type;
  logic          mem_busy = 1'b0, mem_output_valid = 1'b0, mem_write_ready = 1'b0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_err(if_err),
    .ls_load(ls_load), .ls_store(ls_store), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_word_type(ls_word_type), .ls_signed(ls_signed), .ls_rdata(ls_rdata),
    .ls_done(ls_done), .ls_err(ls_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_load(mem_load), .mem_store(mem_store), .mem_is_signed(mem_is_signed),
    .mem_word_type(mem_word_type), .mem_busy(mem_busy),
    .mem_output_valid(mem_output_valid), .mem_write_ready(mem_write_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_fetch;
    logic          err;
    logic          chk_data;
    logic [DW-1:0] rdata;
  } resp_t;

  typedef struct {
    logic          is_store;
    logic [AW-1:0] addr;
    logic [1:0]    wt;
    logic          sgn;
    logic [DW-1:0] wdata;
  } strobe_t;

  resp_t   rq[$];
  strobe_t mq[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, strobe_cyc = -1, resp_cyc = -1;
  logic          resp_en = 1'b1;
  int            resp_lat = 1;
  logic [DW-1:0] resp_data = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_resp(input logic is_fetch, input logic err, input logic chk, input logic [DW-1:0] d);
    resp_t e;
    e.is_fetch = is_fetch; e.err = err; e.chk_data = chk; e.rdata = d;
    rq.push_back(e);
  endtask

  task automatic push_strobe(input logic st, input logic [AW-1:0] a, input logic [1:0] wt,
                             input logic sg, input logic [DW-1:0] wd);
    strobe_t s;
    s.is_store = st; s.addr = a; s.wt = wt; s.sgn = sg; s.wdata = wd;
    mq.push_back(s);
  endtask

  function automatic logic [11:0] out_bits();
    return {|if_rdata, if_valid, if_err, |ls_rdata, ls_done, ls_err,
            |mem_address, |mem_data_in, mem_load, mem_store, mem_is_signed, |mem_word_type};
  endfunction

  // Response monitor
  always @(negedge clk) begin
    resp_t e;
    if (!reset && (if_valid || if_err || ls_done || ls_err)) begin
      resp_cyc = cyc;
      if (rq.size() == 0) begin
        check("unexpected_resp", {28'd0, if_valid, if_err, ls_done, ls_err}, '0);
      end else begin
        e = rq.pop_front();
        check("resp_flags", {28'd0, if_valid, if_err, ls_done, ls_err},
              e.is_fetch ? {28'd0, !e.err, e.err, 2'b00} : {28'd0, 2'b00, 1'b1, e.err});
        if (e.chk_data) check("resp_rdata", e.is_fetch ? if_rdata : ls_rdata, e.rdata);
      end
    end
  end

  // Memory strobe monitor
  always @(negedge clk) begin
    strobe_t s;
    if (!reset && (mem_load || mem_store)) begin
      strobe_cyc = cyc;
      check("strobe_while_busy", {31'd0, mem_busy}, '0);
      if (mq.size() == 0) begin
        check("unexpected_strobe", {30'd0, mem_load, mem_store}, '0);
      end else begin
        s = mq.pop_front();
        check("strobe_kind", {30'd0, mem_load, mem_store}, {30'd0, !s.is_store, s.is_store});
        check("strobe_addr", DW'(mem_address), DW'(s.addr));
        check("strobe_type", DW'(mem_word_type), DW'(s.wt));
        check("strobe_signed", DW'(mem_is_signed), DW'(s.sgn));
        if (s.is_store) check("strobe_wdata", mem_data_in, s.wdata);
      end
    end
  end

  // Memory responder: completion resp_lat cycles after the strobe cycle
  initial begin
    logic is_st;
    forever begin
      @(negedge clk);
      if (!reset && (mem_load || mem_store) && resp_en) begin
        is_st = mem_store;
        repeat (resp_lat) @(posedge clk);
        #1;
        mem_data_out     = resp_data;
        mem_output_valid = !is_st;
        mem_write_ready  = is_st;
        @(posedge clk); #1;
        mem_output_valid = 1'b0;
        mem_write_ready  = 1'b0;
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((rq.size() != 0 || mq.size() != 0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, DW'(rq.size() + mq.size()), '0);
  endtask

  task automatic run_fetch(input logic [AW-1:0] a, input int budget, output int c0);
    @(posedge clk); #1;
    c0 = cyc; if_addr = a; if_req = 1'b1;
    wait_drain("fetch_drain", budget);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic run_ls(input logic ld, input logic st, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [1:0] wt, input logic sg, input int budget, output int c0);
    @(posedge clk); #1;
    c0 = cyc; ls_load = ld; ls_store = st; ls_addr = a; ls_wdata = wd; ls_word_type = wt; ls_signed = sg;
    wait_drain("ls_drain", budget);
    @(posedge clk); #1;
    ls_load = 1'b0; ls_store = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", DW'(out_bits()), '0);
    reset = 1'b0;

    // Single fetch, memory answers 3 cycles after the strobe
    resp_lat = 3; resp_data = 32'hDEADBEEF;
    push_strobe(1'b0, 12'h010, 2'b10, 1'b0, '0);
    push_resp(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    run_fetch(12'h010, 50, c0);
    check("fetch_strobe_lat", DW'(strobe_cyc - c0), 32'd1);
    check("fetch_resp_lat", DW'(resp_cyc - strobe_cyc), 32'd4);

    // Both requesters held high after reset: fetch, ls, fetch, ls
    apply_reset();
    resp_lat = 1; resp_data = 32'h11112222;
    for (int i = 0; i < 2; i++) begin
      push_strobe(1'b0, 12'h020, 2'b10, 1'b0, '0);
      push_resp(1'b1, 1'b0, 1'b1, 32'h11112222);
      push_strobe(1'b0, 12'h030, 2'b10, 1'b0, '0);
      push_resp(1'b0, 1'b0, 1'b1, 32'h11112222);
    end
    @(posedge clk); #1;
    if_addr = 12'h020; if_req = 1'b1;
    ls_addr = 12'h030; ls_word_type = 2'b10; ls_signed = 1'b0; ls_load = 1'b1;
    wait_drain("rr_drain", 100);
    @(posedge clk); #1;
    if_req = 1'b0; ls_load = 1'b0;

    // Misaligned halfword store: immediate error, no memory strobe
    push_resp(1'b0, 1'b1, 1'b0, '0);
    run_ls(1'b0, 1'b1, 12'h003, 32'h0000BEEF, 2'b01, 1'b0, 20, c0);
    check("misaligned_err_lat", DW'(resp_cyc - c0), 32'd1);

    // Signed byte load while memory is busy for 4 cycles
    resp_lat = 2; resp_data = 32'hFFFFFF80;
    push_strobe(1'b0, 12'h005, 2'b00, 1'b1, '0);
    push_resp(1'b0, 1'b0, 1'b1, 32'hFFFFFF80);
    @(posedge clk); #1;
    c0 = cyc; mem_busy = 1'b1;
    ls_load = 1'b1; ls_addr = 12'h005; ls_word_type = 2'b00; ls_signed = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    mem_busy = 1'b0;
    wait_drain("busy_drain", 50);
    @(posedge clk); #1;
    ls_load = 1'b0; ls_signed = 1'b0;
    check("busy_strobe_lat", DW'(strobe_cyc - c0), 32'd4);

    // Store never acknowledged: timeout after 255 WAIT cycles, rdata cleared
    resp_en = 1'b0;
    push_strobe(1'b1, 12'h008, 2'b10, 1'b0, 32'hCAFEF00D);
    push_resp(1'b0, 1'b1, 1'b1, '0);
    run_ls(1'b0, 1'b1, 12'h008, 32'hCAFEF00D, 2'b10, 1'b0, 400, c0);
    check("timeout_lat", DW'(resp_cyc - strobe_cyc), 32'd256);

    // Completion signals while idle must be ignored
    @(posedge clk); #1;
    mem_output_valid = 1'b1; mem_write_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_output_valid = 1'b0; mem_write_ready = 1'b0;
    repeat (3) @(posedge clk);
    resp_en = 1'b1;

    // Illegal requests and an aligned halfword at the edge of legality
    push_resp(1'b1, 1'b1, 1'b0, '0);
    run_fetch(12'h002, 20, c0);
    check("fetch_err_lat", DW'(resp_cyc - c0), 32'd1);
    push_resp(1'b0, 1'b1, 1'b0, '0);
    run_ls(1'b1, 1'b0, 12'h006, '0, 2'b10, 1'b0, 20, c0);
    push_resp(1'b0, 1'b1, 1'b0, '0);
    run_ls(1'b1, 1'b0, 12'h000, '0, 2'b11, 1'b0, 20, c0);
    push_resp(1'b0, 1'b1, 1'b0, '0);
    run_ls(1'b1, 1'b1, 12'h000, '0, 2'b10, 1'b0, 20, c0);
    resp_lat = 1; resp_data = 32'h00007FFF;
    push_strobe(1'b0, 12'h006, 2'b01, 1'b0, '0);
    push_resp(1'b0, 1'b0, 1'b1, 32'h00007FFF);
    run_ls(1'b1, 1'b0, 12'h006, '0, 2'b01, 1'b0, 30, c0);

    // A completed store leaves ls_rdata at the previous load value
    resp_lat = 2; resp_data = 32'h12345678;
    push_strobe(1'b0, 12'h00C, 2'b10, 1'b0, '0);
    push_resp(1'b0, 1'b0, 1'b1, 32'h12345678);
    run_ls(1'b1, 1'b0, 12'h00C, '0, 2'b10, 1'b0, 30, c0);
    resp_lat = 1; resp_data = 32'h0;
    push_strobe(1'b1, 12'h00D, 2'b00, 1'b0, 32'h000000AB);
    push_resp(1'b0, 1'b0, 1'b1, 32'h12345678);
    run_ls(1'b0, 1'b1, 12'h00D, 32'h000000AB, 2'b00, 1'b0, 30, c0);

    // Reset during WAIT: outputs clear at once, then fetch wins first
    resp_en = 1'b0;
    push_strobe(1'b0, 12'h014, 2'b10, 1'b0, '0);
    @(posedge clk); #1;
    if_addr = 12'h014; if_req = 1'b1;
    n = 0;
    while (mq.size() != 0 && n < 20) begin @(negedge clk); #1; n++; end
    check("reset_test_strobe", DW'(mq.size()), '0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("reset_mid_wait_outputs", DW'(out_bits()), '0);
    ls_load = 1'b1; ls_addr = 12'h040; ls_word_type = 2'b10; ls_signed = 1'b0;
    resp_en = 1'b1; resp_lat = 2; resp_data = 32'h0BADF00D;
    push_strobe(1'b0, 12'h014, 2'b10, 1'b0, '0);
    push_resp(1'b1, 1'b0, 1'b1, 32'h0BADF00D);
    push_strobe(1'b0, 12'h040, 2'b10, 1'b0, '0);
    push_resp(1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_drain("post_reset_drain", 60);
    @(posedge clk); #1;
    if_req = 1'b0; ls_load = 1'b0;

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
